// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the board reset/boot sequencer.
package reset_sequencer_pkg;

  localparam int unsigned POR_CYCLES_DEF        = 1024;
  localparam int unsigned FLASH_RST_CYCLES_DEF  = 64;
  localparam int unsigned FLASH_WAKE_CYCLES_DEF = 2048;
  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 256;
  localparam int unsigned CNT_WIDTH_DEF         = 16;

  typedef enum logic [1:0] {
    POR_HOLD   = 2'd0,
    FLASH_RST  = 2'd1,
    FLASH_WAKE = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_SW     = 2'd2;

  // Board-facing pin levels for one sequencer state.
  typedef struct packed {
    logic soc_reset;
    logic spi_rst;
    logic spi_wp;
    logic spi_hold;
    logic ready;
  } pins_t;

  // Pin levels decoded from a state; hold is never asserted.
  function automatic pins_t decode_pins(input state_t s);
    pins_t p;
    p.soc_reset = 1'b1;
    p.spi_rst   = 1'b1;
    p.spi_wp    = 1'b0;
    p.spi_hold  = 1'b1;
    p.ready     = 1'b0;
    case (s)
      FLASH_RST: p.spi_rst = 1'b0;
      RUN: begin
        p.soc_reset = 1'b0;
        p.spi_wp    = 1'b1;
        p.ready     = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/reset_sequencer_button_debounce.sv
// Push-button synchronizer, debouncer and press-event generator.
module button_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_n,
  output logic press
);

  logic [1:0]           sync_ff;
  logic                 sampled;
  logic                 level;
  logic [CNT_WIDTH-1:0] cnt;

  assign sampled = sync_ff[1];

  // Two-flop synchronizer; released button reads high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], button_n};
  end

  // Accept a new level only after it persists; emit a pulse on debounced press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (sampled != level) begin
        if (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
          level <= sampled;
          press <= ~sampled;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / button / software reset sequencer for SoC and SPI flash.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned POR_CYCLES        = POR_CYCLES_DEF,
  parameter int unsigned FLASH_RST_CYCLES  = FLASH_RST_CYCLES_DEF,
  parameter int unsigned FLASH_WAKE_CYCLES = FLASH_WAKE_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH         = CNT_WIDTH_DEF
) (
  input  logic       io_clock,
  input  logic       io_resetn,
  input  logic       io_button_n,
  input  logic       io_swReset,
  output logic       io_socReset,
  output logic       io_spi0_rst,
  output logic       io_spi0_wp,
  output logic       io_spi0_hold,
  output logic       io_ready,
  output logic [1:0] io_resetCause
);

  logic [1:0]           rst_ff;
  logic                 rst_sync;
  logic                 press;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  pins_t                pins;

  assign rst_sync = rst_ff[1];

  // Async-assert, sync-release board reset.
  always_ff @(posedge io_clock or negedge io_resetn) begin
    if (!io_resetn) rst_ff <= 2'b00;
    else            rst_ff <= {rst_ff[0], 1'b1};
  end

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_debounce (
    .clk     (io_clock),
    .rst_n   (rst_sync),
    .button_n(io_button_n),
    .press   (press)
  );

  // Sequencer: timed phases, reset events in RUN, pins registered with the state.
  always_ff @(posedge io_clock or negedge rst_sync) begin
    if (!rst_sync) begin
      state         <= POR_HOLD;
      cnt           <= '0;
      pins          <= decode_pins(POR_HOLD);
      io_resetCause <= CAUSE_POR;
    end else begin
      case (state)
        POR_HOLD: begin
          if (cnt == CNT_WIDTH'(POR_CYCLES - 1)) begin
            state <= FLASH_RST;
            pins  <= decode_pins(FLASH_RST);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        FLASH_RST: begin
          if (cnt == CNT_WIDTH'(FLASH_RST_CYCLES - 1)) begin
            state <= FLASH_WAKE;
            pins  <= decode_pins(FLASH_WAKE);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        FLASH_WAKE: begin
          if (cnt == CNT_WIDTH'(FLASH_WAKE_CYCLES - 1)) begin
            state <= RUN;
            pins  <= decode_pins(RUN);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          // Button has priority over a coincident software request.
          if (press || io_swReset) begin
            state         <= FLASH_RST;
            pins          <= decode_pins(FLASH_RST);
            cnt           <= '0;
            io_resetCause <= press ? CAUSE_BUTTON : CAUSE_SW;
          end
        end
      endcase
    end
  end

  assign io_socReset  = pins.soc_reset;
  assign io_spi0_rst  = pins.spi_rst;
  assign io_spi0_wp   = pins.spi_wp;
  assign io_spi0_hold = pins.spi_hold;
  assign io_ready     = pins.ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scoreboard bench for reset_sequencer with shortened phase lengths.
module tb_reset_sequencer;

  localparam int unsigned POR  = 16;
  localparam int unsigned RST  = 4;
  localparam int unsigned WAKE = 8;
  localparam int unsigned DEB  = 5;

  logic       io_clock = 1'b0;
  logic       io_resetn;
  logic       io_button_n;
  logic       io_swReset;
  logic       io_socReset;
  logic       io_spi0_rst;
  logic       io_spi0_wp;
  logic       io_spi0_hold;
  logic       io_ready;
  logic [1:0] io_resetCause;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  reset_sequencer #(
    .POR_CYCLES       (POR),
    .FLASH_RST_CYCLES (RST),
    .FLASH_WAKE_CYCLES(WAKE),
    .DEBOUNCE_CYCLES  (DEB),
    .CNT_WIDTH        (16)
  ) dut (
    .io_clock     (io_clock),
    .io_resetn    (io_resetn),
    .io_button_n  (io_button_n),
    .io_swReset   (io_swReset),
    .io_socReset  (io_socReset),
    .io_spi0_rst  (io_spi0_rst),
    .io_spi0_wp   (io_spi0_wp),
    .io_spi0_hold (io_spi0_hold),
    .io_ready     (io_ready),
    .io_resetCause(io_resetCause)
  );

  always #5 io_clock = ~io_clock;

  // Expected pin vector {soc, spi_rst, wp, hold, ready, cause}.
  task automatic push(input string tag, input logic soc, input logic srst,
                      input logic wp, input logic rdy, input logic [1:0] cause);
    exp_t e;
    e.tag = tag;
    e.val = {soc, srst, wp, 1'b1, rdy, cause};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [6:0] obs;
    obs = {io_socReset, io_spi0_rst, io_spi0_wp, io_spi0_hold, io_ready, io_resetCause};
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  task automatic push_reset(input string tag);
    push(tag, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  // Stay in RUN for n cycles with the given cause.
  task automatic run_cycles(input string tag, input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++) begin
      push(tag, 1'b0, 1'b1, 1'b1, 1'b1, cause);
      tick();
      pop_check();
    end
  endtask

  // Event sampled on the first edge; flash reset, wake, then RUN.
  task automatic trace_reboot(input string tag, input logic [1:0] cause, input int pulse_at);
    for (int i = 0; i < 16; i++) begin
      if (i == pulse_at) io_swReset = 1'b1;
      if (i < int'(RST))             push(tag, 1'b1, 1'b0, 1'b0, 1'b0, cause);
      else if (i < int'(RST + WAKE)) push(tag, 1'b1, 1'b1, 1'b0, 1'b0, cause);
      else                           push(tag, 1'b0, 1'b1, 1'b1, 1'b1, cause);
      tick();
      io_swReset = 1'b0;
      pop_check();
    end
  endtask

  // io_resetn released just after edge 0; check edges 1..n.
  task automatic boot_trace(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      if (e < int'(POR + 2))                  push(tag, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      else if (e < int'(POR + 2 + RST))       push(tag, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      else if (e < int'(POR + 2 + RST + WAKE)) push(tag, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      else                                    push(tag, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
      tick();
      pop_check();
    end
  endtask

  initial begin
    io_resetn   = 1'b0;
    io_button_n = 1'b1;
    io_swReset  = 1'b0;
    repeat (3) tick();
    push_reset("reset_values");
    pop_check();

    // Power-on boot
    io_resetn = 1'b1;
    boot_trace("boot", 40);

    // Short press below the debounce window
    io_button_n = 1'b0;
    run_cycles("short_press", 4, 2'd0);
    io_button_n = 1'b1;
    run_cycles("short_release", 20, 2'd0);

    // Real press, then held
    io_button_n = 1'b0;
    run_cycles("press_debounce", 7, 2'd0);
    trace_reboot("press_reboot", 2'd1, -1);
    run_cycles("press_held", 100, 2'd1);
    io_button_n = 1'b1;
    run_cycles("press_release", 20, 2'd1);

    // Software reset
    io_swReset = 1'b1;
    trace_reboot("sw_reboot", 2'd2, -1);
    run_cycles("sw_after", 10, 2'd2);

    // Software pulse during FLASH_WAKE is ignored
    io_swReset = 1'b1;
    trace_reboot("sw_wake_pulse", 2'd2, 6);
    run_cycles("sw_wake_after", 20, 2'd2);

    // Debounced press edge coincident with software request
    io_button_n = 1'b0;
    run_cycles("sim_debounce", 7, 2'd2);
    io_swReset = 1'b1;
    trace_reboot("simultaneous", 2'd1, -1);
    run_cycles("sim_after", 10, 2'd1);
    io_button_n = 1'b1;
    run_cycles("sim_release", 20, 2'd1);

    // Glitch train never settles long enough
    for (int i = 0; i < 50; i++) begin
      io_button_n = ((i >> 1) & 1) != 0 ? 1'b0 : 1'b1;
      push("glitch", 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
      tick();
      pop_check();
    end
    io_button_n = 1'b1;
    run_cycles("glitch_after", 10, 2'd1);
    checks++;
    assert (dut.u_debounce.level === 1'b1) else begin
      errors++;
      $error("FAIL glitch_level observed=%b expected=1", dut.u_debounce.level);
    end

    // Board reset asserted during FLASH_RST
    io_swReset = 1'b1;
    tick();
    io_swReset = 1'b0;
    tick();
    push("mid_pre", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    pop_check();
    #2;
    io_resetn = 1'b0;
    #1;
    push_reset("mid_async");
    pop_check();
    repeat (3) tick();
    push_reset("mid_held");
    pop_check();
    io_resetn = 1'b1;
    boot_trace("reboot_por", 40);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
